// File: rtl/delay_line_frame_rx_if.sv
// Byte stream into the frame receiver and the replayed payload stream out of it.
interface delay_line_frame_rx_if;
  logic       in_en;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;

  modport master (
    output in_en, in_data, out_ready,
    input  out_valid, out_data, out_last
  );

  modport slave (
    input  in_en, in_data, out_ready,
    output out_valid, out_data, out_last
  );
endinterface

// File: rtl/delay_line_frame_rx.sv
// Frame receiver for the delay-line byte stream: SYNC, LEN, payload, XOR checksum.
// Verified payloads are replayed from a local buffer on a valid/ready stream.
module delay_line_frame_rx #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         MAX_LEN   = 16,
  parameter int         CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  delay_line_frame_rx_if.slave lane,
  output logic                 frame_ok,
  output logic                 frame_err,
  output logic                 drop,
  output logic [CNT_W-1:0]     ok_cnt,
  output logic [CNT_W-1:0]     err_cnt
);

  localparam int               IDX_W     = $clog2(MAX_LEN + 1);
  localparam int               MEM_D     = 1 << IDX_W;
  localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [IDX_W-1:0] ONE       = IDX_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {HUNT, LEN, PAY, CHK, DRAIN} state_t;

  state_t           state;
  logic [IDX_W-1:0] len;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] rd;
  logic [7:0]       chk;
  logic             valid;
  logic [7:0]       data;
  logic             last;

  // Indexed by the full IDX_W-bit pointer so no index truncation is needed.
  logic [7:0] mem [MEM_D];

  logic [IDX_W-1:0] len_m1;
  logic [IDX_W-1:0] rd_next;
  logic             len_legal;
  logic             handshake;

  assign len_m1    = len - ONE;
  assign rd_next   = rd + ONE;
  assign len_legal = (lane.in_data != 8'd0) && (lane.in_data <= MAX_LEN_B);
  assign handshake = valid && lane.out_ready;

  assign lane.out_valid = valid;
  assign lane.out_data  = data;
  assign lane.out_last  = last;

  always_ff @(posedge clk) begin
    if (state == PAY && lane.in_en) begin
      mem[idx] <= lane.in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= HUNT;
      len       <= '0;
      idx       <= '0;
      rd        <= '0;
      chk       <= '0;
      valid     <= 1'b0;
      data      <= '0;
      last      <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      drop      <= 1'b0;
      ok_cnt    <= '0;
      err_cnt   <= '0;
    end else begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      drop      <= 1'b0;
      case (state)
        HUNT: begin
          if (lane.in_en && lane.in_data == SYNC_BYTE) begin
            state <= LEN;
          end
        end
        LEN: begin
          if (lane.in_en) begin
            if (len_legal) begin
              len   <= lane.in_data[IDX_W-1:0];
              chk   <= lane.in_data;
              idx   <= '0;
              state <= PAY;
            end else begin
              frame_err <= 1'b1;
              if (err_cnt != '1) err_cnt <= err_cnt + CNT_ONE;
              state <= HUNT;
            end
          end
        end
        PAY: begin
          if (lane.in_en) begin
            chk <= chk ^ lane.in_data;
            idx <= idx + ONE;
            if (idx == len_m1) state <= CHK;
          end
        end
        CHK: begin
          if (lane.in_en) begin
            if (lane.in_data == chk) begin
              frame_ok <= 1'b1;
              if (ok_cnt != '1) ok_cnt <= ok_cnt + CNT_ONE;
              // First byte is presented together with the frame_ok pulse.
              rd    <= '0;
              valid <= 1'b1;
              data  <= mem[0];
              last  <= (len == ONE);
              state <= DRAIN;
            end else begin
              frame_err <= 1'b1;
              if (err_cnt != '1) err_cnt <= err_cnt + CNT_ONE;
              state <= HUNT;
            end
          end
        end
        DRAIN: begin
          if (lane.in_en) drop <= 1'b1;
          if (handshake) begin
            if (last) begin
              valid <= 1'b0;
              last  <= 1'b0;
              state <= HUNT;
            end else begin
              rd   <= rd_next;
              data <= mem[rd_next];
              last <= (rd_next == len_m1);
            end
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_delay_line_frame_rx.sv
// Randomized and directed checks of the frame receiver against a frame-level
// model: expected payload queue plus good/bad frame tallies.
module tb_delay_line_frame_rx;
  localparam logic [7:0] SYNC    = 8'hA5;
  localparam int         MAX_LEN = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_ok, frame_err, drop;
  logic [7:0] ok_cnt, err_cnt;

  always #5 clk = ~clk;

  delay_line_frame_rx_if lane ();

  delay_line_frame_rx #(.SYNC_BYTE(SYNC), .MAX_LEN(MAX_LEN), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .lane      (lane.slave),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .drop      (drop),
    .ok_cnt    (ok_cnt),
    .err_cnt   (err_cnt)
  );

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [8:0] exp_q[$];
  int         ok_seen = 0, err_seen = 0, drop_seen = 0;
  int         exp_ok = 0, exp_err = 0;
  bit         rand_ready = 1'b0;
  bit         stall = 1'b0;
  logic [7:0] prev_data;
  logic       prev_last;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Output monitor: scoreboard against the expected payload queue.
  always @(negedge clk) begin
    logic [8:0] e;
    if (rst) begin
      stall = 1'b0;
    end else begin
      if (frame_ok)  ok_seen++;
      if (frame_err) err_seen++;
      if (drop)      drop_seen++;
      if (stall)
        check("hold", {lane.out_valid, lane.out_last, lane.out_data},
              {1'b1, prev_last, prev_data});
      if (lane.out_valid && lane.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("out_data", lane.out_data, e[7:0]);
          check("out_last", lane.out_last, e[8]);
        end
      end
      stall     = lane.out_valid && !lane.out_ready;
      prev_data = lane.out_data;
      prev_last = lane.out_last;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) lane.out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    lane.in_en   = 1'b1;
    lane.in_data = b;
    tick();
    lane.in_en   = 1'b0;
  endtask

  task automatic send_gap(input logic [7:0] b, input int max_gap);
    repeat ($urandom_range(0, max_gap)) tick();
    send_byte(b);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400 && (exp_q.size() != 0 || lane.out_valid); i++) tick();
    check("drain_timeout", int'(exp_q.size() == 0 && !lane.out_valid), 1);
  endtask

  // Asserts reset between clock edges and checks that outputs clear at once.
  task automatic apply_reset();
    rst = 1'b1;
    #1;
    check("rst_valid", lane.out_valid, 0);
    check("rst_last", lane.out_last, 0);
    check("rst_data", lane.out_data, 0);
    check("rst_pulses", {frame_ok, frame_err, drop}, 0);
    check("rst_ok_cnt", ok_cnt, 0);
    check("rst_err_cnt", err_cnt, 0);
    exp_q.delete();
    tick();
    rst = 1'b0;
    exp_ok  = 0;
    exp_err = 0;
    tick();
  endtask

  // Frame-level model: legality of LEN and XOR checksum decide the outcome.
  task automatic send_frame(input int len_v, input bit bad_chk, input int max_gap);
    logic [7:0] p[$];
    logic [7:0] c;
    logic [7:0] b;
    bit         legal;
    legal = (len_v >= 1) && (len_v <= MAX_LEN);
    c = 8'(len_v);
    send_gap(SYNC, max_gap);
    send_gap(8'(len_v), max_gap);
    if (!legal) begin
      exp_err++;
      $display("frame len=%0d bad_len", len_v);
    end else begin
      for (int i = 0; i < len_v; i++) begin
        b = 8'($urandom);
        p.push_back(b);
        c = c ^ b;
        send_gap(b, max_gap);
      end
      if (bad_chk) begin
        exp_err++;
        c = c ^ 8'($urandom_range(1, 255));
      end else begin
        exp_ok++;
        for (int i = 0; i < len_v; i++) exp_q.push_back({(i == len_v - 1), p[i]});
      end
      send_gap(c, max_gap);
      $display("frame len=%0d chk=%02h %s", len_v, c, bad_chk ? "bad_chk" : "good");
    end
    wait_idle();
  endtask

  initial begin
    int d0, e0, o0;
    rst           = 1'b1;
    lane.in_en    = 1'b0;
    lane.in_data  = 8'h00;
    lane.out_ready = 1'b1;
    tick();
    apply_reset();

    // Good 3-byte frame with exact output timing.
    exp_q.push_back({1'b0, 8'h11});
    exp_q.push_back({1'b0, 8'h22});
    exp_q.push_back({1'b1, 8'h33});
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
    send_byte(8'h22); send_byte(8'h33); send_byte(8'h03);
    check("t1_ok_pulse", frame_ok, 1);
    check("t1_first", {lane.out_valid, lane.out_last, lane.out_data}, {2'b10, 8'h11});
    tick();
    check("t1_ok_once", frame_ok, 0);
    check("t1_second", {lane.out_valid, lane.out_last, lane.out_data}, {2'b10, 8'h22});
    tick();
    check("t1_third", {lane.out_valid, lane.out_last, lane.out_data}, {2'b11, 8'h33});
    tick();
    check("t1_done", lane.out_valid, 0);
    check("t1_ok_cnt", ok_cnt, 1);
    $display("txn good3 ok_cnt=%0d", ok_cnt);

    // Checksum mismatch, then a good frame to show HUNT was re-entered.
    apply_reset();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10);
    send_byte(8'h20); send_byte(8'h31);
    check("t2_err_pulse", frame_err, 1);
    check("t2_no_valid", lane.out_valid, 0);
    tick();
    check("t2_err_cnt", err_cnt, 1);
    check("t2_err_once", frame_err, 0);
    send_frame(1, 1'b0, 0);
    check("t2_recover", ok_cnt, 1);
    $display("txn bad_chk err_cnt=%0d", err_cnt);

    // Illegal LEN values at both ends; maximum legal LEN still accepted.
    apply_reset();
    e0 = err_seen;
    send_byte(8'hA5); send_byte(8'h00); tick();
    send_byte(8'hA5); send_byte(8'h11); tick();
    check("t3_err_cnt", err_cnt, 2);
    check("t3_err_pulses", err_seen - e0, 2);
    send_frame(MAX_LEN, 1'b0, 1);
    check("t3_max_len_ok", ok_cnt, 1);
    $display("txn bad_len err_cnt=%0d ok_cnt=%0d", err_cnt, ok_cnt);

    // Backpressure with bytes strobed during DRAIN.
    apply_reset();
    lane.out_ready = 1'b0;
    exp_q.push_back({1'b0, 8'h5A});
    exp_q.push_back({1'b1, 8'hC3});
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h5A);
    send_byte(8'hC3); send_byte(8'h9B);
    check("t4_ok_pulse", frame_ok, 1);
    d0 = drop_seen;
    for (int i = 0; i < 5; i++) begin
      if (i % 2 == 0) send_byte(8'($urandom));
      else tick();
      check("t4_stall_data", {lane.out_valid, lane.out_data}, {1'b1, 8'h5A});
    end
    tick();
    check("t4_drops", drop_seen - d0, 3);
    lane.out_ready = 1'b1;
    wait_idle();
    check("t4_ok_cnt", ok_cnt, 1);
    $display("txn backpressure drops=%0d", drop_seen - d0);

    // Noise before SYNC, SYNC value inside the payload, double SYNC.
    apply_reset();
    exp_q.push_back({1'b0, 8'hA5});
    exp_q.push_back({1'b1, 8'h07});
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'hA5); send_byte(8'h02);
    send_byte(8'hA5); send_byte(8'h07); send_byte(8'hA0);
    wait_idle();
    check("t5_ok_cnt", ok_cnt, 1);
    check("t5_err_cnt", err_cnt, 0);
    send_byte(8'hA5); send_byte(8'hA5); tick();
    check("t5_sync_as_len", err_cnt, 1);
    $display("txn sync_in_payload ok_cnt=%0d err_cnt=%0d", ok_cnt, err_cnt);

    // Reset mid-payload and mid-drain; later frames decode with gaps.
    apply_reset();
    send_byte(8'hA5); send_byte(8'h04); send_byte(8'h11); send_byte(8'h22);
    apply_reset();
    send_frame(3, 1'b0, 3);
    check("t6_after_pay_rst", ok_cnt, 1);
    lane.out_ready = 1'b0;
    exp_q.push_back({1'b0, 8'h01});
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h01);
    send_byte(8'h02); send_byte(8'h01);
    check("t6_draining", lane.out_valid, 1);
    apply_reset();
    lane.out_ready = 1'b1;
    send_frame(4, 1'b0, 2);
    check("t6_after_drain_rst", ok_cnt, 1);
    $display("txn reset_recovery ok_cnt=%0d", ok_cnt);

    // Randomized frames with random backpressure and gaps.
    apply_reset();
    o0 = ok_seen;
    e0 = err_seen;
    rand_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      int len_v;
      logic [7:0] nz;
      repeat ($urandom_range(0, 3)) begin
        nz = 8'($urandom);
        if (nz == SYNC) nz = 8'h5A;
        send_byte(nz);
      end
      if ($urandom_range(0, 4) == 0)
        len_v = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(MAX_LEN + 1, 255);
      else
        len_v = $urandom_range(1, MAX_LEN);
      send_frame(len_v, ($urandom_range(0, 3) == 0), 2);
    end
    rand_ready = 1'b0;
    lane.out_ready = 1'b1;
    tick();
    check("rnd_ok_cnt", ok_cnt, exp_ok);
    check("rnd_err_cnt", err_cnt, exp_err);
    check("rnd_ok_pulses", ok_seen - o0, exp_ok);
    check("rnd_err_pulses", err_seen - e0, exp_err);

    // Error counter saturation.
    apply_reset();
    e0 = err_seen;
    for (int n = 0; n < 260; n++) begin
      send_byte(8'hA5);
      send_byte(8'h00);
    end
    tick();
    check("sat_err_cnt", err_cnt, 255);
    check("sat_err_pulses", err_seen - e0, 260);
    check("sat_ok_cnt", ok_cnt, 0);
    $display("txn saturation err_cnt=%0d", err_cnt);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
